// File: rtl/dmem_if.sv
// Load/store bus between the CPU datapath and the data memory.
// The datapath (master) drives address, write enable and write data;
// the memory (slave) returns combinational read data.
interface dmem_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) ();

  logic              wm;
  logic [DATA_W-1:0] in;
  logic [ADDR_W-1:0] ad;
  logic [DATA_W-1:0] out;

  modport master (
    output wm,
    output in,
    output ad,
    input  out
  );

  modport slave (
    input  wm,
    input  in,
    input  ad,
    output out
  );

endinterface

// File: rtl/dmem.sv
// Data memory for the 8-bit datapath.
// Synchronous single write port, asynchronous read port, both addressed by `ad`.
// Asynchronous reset loads every word with its own address (identity pattern),
// so a freshly reset memory never returns X and reads back as out == ad.
module dmem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  // The address bus covers the whole array, so no range or wrap logic exists.
  parameter int unsigned DEPTH  = 256
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage: identity load while reset is low (writes discarded), else write on wm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(i);
      end
    end else if (bus.wm) begin
      mem_q[bus.ad] <= bus.in;
    end
  end

  // Combinational read, not gated by wm: a write shows up right after its edge.
  always_comb begin
    bus.out = mem_q[bus.ad];
  end

endmodule

// File: tb/tb_dmem.sv
// Randomised self-checking bench for dmem.
// Stimulus pushes the expected read value into a queue each cycle; an
// independent monitor pops and compares against `out` on the falling edge.
module tb_dmem;

  logic clk;
  logic rst_n;

  dmem_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  dmem #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain array of words.
  logic [7:0] model [256];

  // Scoreboard queues.
  string      name_q [$];
  logic [7:0] exp_q  [$];
  logic [7:0] adr_q  [$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] last_a;

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) model[i] = 8'(i);
  endfunction

  // One bus cycle: drive after the rising edge, expect the pre-edge contents.
  task automatic cyc(input logic w, input logic [7:0] a, input logic [7:0] d,
                     input string nm);
    @(posedge clk);
    #1;
    bus.wm = w;
    bus.ad = a;
    bus.in = d;
    name_q.push_back(nm);
    adr_q.push_back(a);
    exp_q.push_back(rst_n ? model[a] : a);
    if (w && rst_n) model[a] = d;
    last_a = a;
  endtask

  // Drop reset between clock edges; any write driven in this cycle is lost.
  task automatic reset_mid(input logic w, input logic [7:0] a, input logic [7:0] d,
                           input string nm);
    @(posedge clk);
    #1;
    bus.wm = w;
    bus.ad = a;
    bus.in = d;
    name_q.push_back(nm);
    adr_q.push_back(a);
    exp_q.push_back(a);
    #1;
    rst_n = 1'b0;
    model_reset();
  endtask

  task automatic release_rst(input logic [7:0] a, input string nm);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    bus.wm = 1'b0;
    bus.ad = a;
    name_q.push_back(nm);
    adr_q.push_back(a);
    exp_q.push_back(model[a]);
  endtask

  // Monitor: compare whenever an expectation is outstanding.
  initial begin
    string      nm;
    logic [7:0] e;
    logic [7:0] a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        nm = name_q.pop_front();
        e  = exp_q.pop_front();
        a  = adr_q.pop_front();
        n_checks++;
        if (bus.out !== e) begin
          n_fail++;
          $display("FAIL %s: ad=%02h out=%02h expected=%02h", nm, a, bus.out, e);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    int         r;

    rst_n  = 1'b0;
    bus.wm = 1'b0;
    bus.in = 8'h00;
    bus.ad = 8'h00;
    last_a = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full sweep after reset: identity pattern, no X anywhere.
    for (int i = 0; i < 256; i++) cyc(1'b0, 8'(i), 8'h00, "reset_sweep");

    // Write then read back, including the same-address follow-up cycle.
    cyc(1'b1, 8'h03, 8'h03, "wr3_old");
    cyc(1'b0, 8'h03, 8'h00, "rd3_03");
    cyc(1'b1, 8'h03, 8'hA5, "wr3_a5_old");
    cyc(1'b0, 8'h03, 8'h00, "rd3_a5");

    // Isolation of neighbours.
    cyc(1'b1, 8'h10, 8'h5A, "wr10");
    cyc(1'b0, 8'h0F, 8'h00, "rd0f");
    cyc(1'b0, 8'h11, 8'h00, "rd11");
    cyc(1'b0, 8'h10, 8'h00, "rd10");

    // Write-enable gating.
    repeat (4) cyc(1'b0, 8'h20, 8'hFF, "wm0_gate");

    // Boundaries.
    cyc(1'b1, 8'h00, 8'h11, "wr00");
    cyc(1'b1, 8'hFF, 8'hEE, "wrff");
    cyc(1'b0, 8'h00, 8'h00, "rd00");
    cyc(1'b0, 8'hFF, 8'h00, "rdff");
    cyc(1'b0, 8'h01, 8'h00, "rd01");

    // Back-to-back writes, then read all back.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h80 + i), 8'(8'hC0 ^ i), "b2b_wr");
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'(8'h80 + i), 8'h00, "b2b_rd");

    // Async reset mid-operation, writes while in reset are ignored.
    cyc(1'b1, 8'h40, 8'h77, "wr40");
    cyc(1'b0, 8'h40, 8'h00, "rd40_77");
    reset_mid(1'b0, 8'h40, 8'h00, "rst_async40");
    cyc(1'b1, 8'h40, 8'hAB, "rst_wr_ign");
    cyc(1'b1, 8'h41, 8'h99, "rst_wr_ign41");
    cyc(1'b0, 8'h40, 8'h00, "rst_rd40");
    release_rst(8'h41, "rel_rd41");
    cyc(1'b0, 8'h40, 8'h00, "post_rd40");
    cyc(1'b0, 8'h03, 8'h00, "post_rd03");

    // Reset dropped in the same cycle as a write: write is discarded.
    cyc(1'b1, 8'h50, 8'h12, "pre_wr50");
    reset_mid(1'b1, 8'h51, 8'h34, "rst_midwr51");
    release_rst(8'h51, "rel_rd51");
    cyc(1'b0, 8'h50, 8'h00, "post_rd50");

    // Randomised traffic with boundary and repeat-address bias.
    for (int k = 0; k < 600; k++) begin
      r = int'($urandom_range(0, 15));
      if (r < 2)       a = 8'h00;
      else if (r < 4)  a = 8'hFF;
      else if (r < 8)  a = last_a;
      else             a = 8'($urandom);
      w = 1'($urandom);
      d = 8'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        reset_mid(w, a, d, "rnd_rst");
        cyc(1'($urandom), 8'($urandom), 8'($urandom), "rnd_in_rst");
        release_rst(a, "rnd_rel");
      end else begin
        cyc(w, a, d, "rnd");
      end
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
